debug_port_host: RTL and testbench
==================================

DEBUG_PORT_HOST -- requirements
Module: debug_port_host

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 255: max cycles to wait for a response after request acceptance (legal range 1..65535).
REQ-002 SHALL provide port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 SHALL provide port cmd_valid  input  1  host command present.
REQ-005 SHALL provide port cmd_ready  output  1  host command accepted this cycle when both cmd_valid and cmd_ready are 1.
REQ-006 SHALL provide port cmd_write  input  1  1 = write, 0 = read.
REQ-007 SHALL provide port cmd_addr  input  32  target address.
REQ-008 SHALL provide port cmd_wdata  input  32  write data; ignored for reads.
REQ-009 SHALL provide port io_debug_port_req_valid  output  1  request to core debug port.
REQ-010 SHALL provide port io_debug_port_req_ready  input  1  core accepts request.
REQ-011 SHALL provide ports io_debug_port_req_bits_addr / _data / _fcn  output  32/32/1  latched cmd_addr, cmd_wdata, cmd_write.
REQ-012 SHALL provide ports io_debug_port_resp_valid / io_debug_port_resp_bits_data  input  1/32  core response.
REQ-013 SHALL provide ports rsp_valid / rsp_ready  output/input  1/1  result handshake to host.
REQ-014 SHALL provide ports rsp_data / rsp_timeout  output  32/1  result data; 1 = no response before TIMEOUT.
REQ-015 SHALL provide port spurious_count  output  8  saturating count of unexpected responses.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, WAIT, DONE; cmd_ready = 1 only in IDLE (decoded from state, no dependence on cmd_valid).
REQ-017 SHALL, on IDLE with cmd_valid=1, latch cmd_write/addr/wdata and go to REQ; io_debug_port_req_valid is 1 on the following cycle (1-cycle latency).
REQ-018 SHALL hold io_debug_port_req_valid=1 and req_bits stable in REQ until io_debug_port_req_ready=1; then go to WAIT and clear the wait counter to 0.
REQ-019 SHALL, in WAIT, increment the wait counter each cycle with io_debug_port_resp_valid=0; the counter never wraps.
REQ-020 SHALL, in WAIT with io_debug_port_resp_valid=1, register rsp_data = io_debug_port_resp_bits_data, rsp_timeout=0, go to DONE (rsp_valid=1 next cycle); applies to reads and writes.
REQ-021 SHALL, in WAIT when the counter reaches TIMEOUT-1 with no response, go to DONE with rsp_data=0, rsp_timeout=1.
REQ-022 SHALL give the response priority when io_debug_port_resp_valid=1 in the same cycle as the timeout condition.
REQ-023 SHALL assert rsp_valid only in DONE, holding rsp_data/rsp_timeout stable until rsp_ready=1; then return to IDLE (back-to-back: next cmd accepted the following cycle).
REQ-024 SHALL treat io_debug_port_resp_valid=1 in IDLE, REQ or DONE as spurious: discard data, increment spurious_count, saturate at 255.
REQ-025 SHALL not accept responses in the same cycle as request acceptance (REQ state); such a response counts as spurious.
REQ-026 SHALL never have more than one request outstanding.

Reset
REQ-027 SHALL, while reset=0, force state IDLE, cmd_ready=1, io_debug_port_req_valid=0, rsp_valid=0, req_bits=0, rsp_data=0, rsp_timeout=0, spurious_count=0, wait counter=0, regardless of clock.
REQ-028 SHALL abandon any in-flight transaction on reset assertion mid-operation; no rsp_valid is produced for it after reset release.

Verification
REQ-029 Read: cmd read addr 0x80000010 at cycle 0, req_ready=1 at cycle 1, resp_valid with data 0xDEADBEEF at cycle 3 -> rsp_valid=1 at cycle 4, rsp_data=0xDEADBEEF, rsp_timeout=0.
REQ-030 Write with backpressure: cmd write addr 0x100 data 0x12345678, req_ready held 0 for 5 cycles -> req_valid, addr=0x100, data=0x12345678, fcn=1 stable all 5 cycles; ack returns rsp_valid with rsp_timeout=0.
REQ-031 Timeout: TIMEOUT=4, no resp after request acceptance -> rsp_valid=1 with rsp_timeout=1, rsp_data=0 exactly 5 cycles after acceptance; resp at the timeout cycle instead -> rsp_timeout=0 with that data.
REQ-032 Spurious: 300 resp_valid pulses while IDLE -> spurious_count=255, no rsp_valid, cmd_ready stays 1.
REQ-033 Reset mid-WAIT: reset=0 for 1 cycle while waiting, then resp_valid=1 -> all outputs at reset values, spurious_count=1, no rsp_valid.
REQ-034 Host stall: rsp_ready=0 for 10 cycles in DONE -> rsp_valid and rsp_data stable, cmd_ready=0; rsp_ready=1 -> cmd_ready=1 next cycle.

Source files
------------

// File: rtl/debug_port_host.sv
// debug_port_host: host-side bridge issuing one request at a time to a core debug port,
// with a response timeout and a saturating count of unexpected responses.
module debug_port_host #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        io_debug_port_req_valid,
    input  logic        io_debug_port_req_ready,
    output logic [31:0] io_debug_port_req_bits_addr,
    output logic [31:0] io_debug_port_req_bits_data,
    output logic        io_debug_port_req_bits_fcn,
    input  logic        io_debug_port_resp_valid,
    input  logic [31:0] io_debug_port_resp_bits_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout,
    output logic [7:0]  spurious_count
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);
    logic [1:0]  state;
    logic [15:0] waitCnt;
    assign cmd_ready               = state == IDLE;
    assign io_debug_port_req_valid = state == REQ;
    assign rsp_valid               = state == DONE;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                       <= IDLE;
            waitCnt                     <= '0;
            io_debug_port_req_bits_addr <= '0;
            io_debug_port_req_bits_data <= '0;
            io_debug_port_req_bits_fcn  <= 1'b0;
            rsp_data                    <= '0;
            rsp_timeout                 <= 1'b0;
            spurious_count              <= '0;
        end else begin
            // only WAIT consumes responses; anything else is counted and dropped
            if (io_debug_port_resp_valid && state != WAIT && spurious_count != 8'hff)
                spurious_count <= spurious_count + 8'd1;
            case (state)
                IDLE: if (cmd_valid) begin
                    state                       <= REQ;
                    io_debug_port_req_bits_addr <= cmd_addr;
                    io_debug_port_req_bits_data <= cmd_wdata;
                    io_debug_port_req_bits_fcn  <= cmd_write;
                end
                REQ: if (io_debug_port_req_ready) begin
                    state   <= WAIT;
                    waitCnt <= '0;
                end
                WAIT: if (io_debug_port_resp_valid) begin
                    state       <= DONE;
                    rsp_data    <= io_debug_port_resp_bits_data;
                    rsp_timeout <= 1'b0;
                end else if (waitCnt == LAST) begin
                    state       <= DONE;
                    rsp_data    <= '0;
                    rsp_timeout <= 1'b1;
                end else if (waitCnt != '1) begin
                    waitCnt <= waitCnt + 16'd1;
                end
                default: if (rsp_ready) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_debug_port_host.sv
// tb_debug_port_host: table-driven transactions scored through a queue, plus hand-written
// sequences for reset, spurious responses and request-cycle responses.
module tb_debug_port_host;
    localparam int TO = 4;
    logic        clock = 0;
    logic        reset = 0;
    logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
    logic [31:0] cmd_addr = 0, cmd_wdata = 0;
    logic        req_valid, req_ready = 0, req_fcn;
    logic [31:0] req_addr, req_data;
    logic        resp_valid = 0;
    logic [31:0] resp_data = 0;
    logic        rsp_valid, rsp_ready = 0, rsp_timeout;
    logic [31:0] rsp_data;
    logic [7:0]  spurious_count;
    int nChk = 0, nFail = 0;

    typedef struct {
        logic        write;
        logic [31:0] addr, wdata, respData;
        int          stall, delay, hostStall;
    } vec_t;
    typedef struct {
        logic [31:0] data;
        logic        timeout;
        int          lat;
    } exp_t;
    vec_t vecs[6];
    exp_t sb[$];

    debug_port_host #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .io_debug_port_req_valid(req_valid), .io_debug_port_req_ready(req_ready),
        .io_debug_port_req_bits_addr(req_addr), .io_debug_port_req_bits_data(req_data),
        .io_debug_port_req_bits_fcn(req_fcn),
        .io_debug_port_resp_valid(resp_valid), .io_debug_port_resp_bits_data(resp_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout), .spurious_count(spurious_count)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkResetState(input string tag);
        check({tag, " cmd_ready"}, cmd_ready, 1);
        check({tag, " req_valid"}, req_valid, 0);
        check({tag, " rsp_valid"}, rsp_valid, 0);
        check({tag, " req_addr"}, req_addr, 0);
        check({tag, " req_data"}, req_data, 0);
        check({tag, " req_fcn"}, req_fcn, 0);
        check({tag, " rsp_data"}, rsp_data, 0);
        check({tag, " rsp_timeout"}, rsp_timeout, 0);
        check({tag, " spurious"}, spurious_count, 0);
    endtask

    task automatic runVec(input vec_t v);
        exp_t e, got;
        int   c;
        logic seen;
        check("cmd_ready before cmd", cmd_ready, 1);
        cmd_valid = 1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
        e.timeout = v.delay >= TO;
        e.data    = e.timeout ? 32'h0 : v.respData;
        e.lat     = e.timeout ? TO - 1 : v.delay;
        sb.push_back(e);
        tick;
        cmd_valid = 0; cmd_write = ~v.write; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata;
        for (int s = 0; s <= v.stall; s++) begin
            check("req_valid", req_valid, 1);
            check("req_addr", req_addr, v.addr);
            check("req_data", req_data, v.wdata);
            check("req_fcn", req_fcn, v.write);
            check("cmd_ready in REQ", cmd_ready, 0);
            req_ready = (s == v.stall);
            tick;
        end
        req_ready = 0;
        check("req_valid after accept", req_valid, 0);
        seen = 0;
        c = 0;
        while (!seen && c < TO + 4) begin
            resp_valid = (c == v.delay);
            resp_data  = v.respData;
            tick;
            resp_valid = 0;
            if (rsp_valid) seen = 1;
            else c++;
        end
        check("rsp_valid arrives", seen, 1);
        if (sb.size() == 0) begin
            nChk++; nFail++;
            $display("FAIL scoreboard: empty queue got 0 expected 1 entry");
        end else begin
            got = sb.pop_front();
            if (seen) begin
                check("rsp latency", c, got.lat);
                check("rsp_data", rsp_data, got.data);
                check("rsp_timeout", rsp_timeout, got.timeout);
            end
        end
        for (int h = 0; h < v.hostStall; h++) begin
            tick;
            check("stall rsp_valid", rsp_valid, 1);
            check("stall rsp_data", rsp_data, got.data);
            check("stall cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1;
        tick;
        rsp_ready = 0;
        check("rsp_valid after ack", rsp_valid, 0);
        check("cmd_ready after ack", cmd_ready, 1);
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0, 1, 0};
        vecs[1] = '{1'b1, 32'h0000_0100, 32'h1234_5678, 32'h0, 5, 0, 0};
        vecs[2] = '{1'b0, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 0, 9, 0};
        vecs[3] = '{1'b0, 32'h0000_0300, 32'h0, 32'hA5A5_A5A5, 1, TO - 1, 0};
        vecs[4] = '{1'b1, 32'h0000_0400, 32'h0BAD_F00D, 32'h5555_0000, 0, 2, 10};
        vecs[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF, 2, 0, 2};

        #3;
        checkResetState("in reset");
        @(posedge clock);
        #1 reset = 1;
        tick;
        checkResetState("after release");

        foreach (vecs[i]) runVec(vecs[i]);
        check("no spurious after vectors", spurious_count, 0);

        // response in the request-acceptance cycle is spurious; request then times out
        cmd_valid = 1; cmd_addr = 32'h0000_0500; cmd_write = 0;
        tick;
        cmd_valid = 0;
        req_ready = 1; resp_valid = 1; resp_data = 32'h1111_2222;
        tick;
        req_ready = 0; resp_valid = 0;
        check("REQ-cycle resp spurious", spurious_count, 1);
        begin
            int c = 0;
            while (!rsp_valid && c < TO + 4) begin
                tick;
                if (!rsp_valid) c++;
            end
            check("REQ-cycle timeout latency", c, TO - 1);
            check("REQ-cycle rsp_timeout", rsp_timeout, 1);
            check("REQ-cycle rsp_data", rsp_data, 0);
        end
        rsp_ready = 1;
        tick;
        rsp_ready = 0;

        for (int i = 0; i < 300; i++) begin
            resp_valid = 1; resp_data = i;
            tick;
            if (rsp_valid !== 0 || cmd_ready !== 1) begin
                check("spurious rsp_valid", rsp_valid, 0);
                check("spurious cmd_ready", cmd_ready, 1);
            end
        end
        resp_valid = 0;
        check("spurious saturates", spurious_count, 8'd255);
        check("spurious no rsp_valid", rsp_valid, 0);
        check("spurious cmd_ready", cmd_ready, 1);

        cmd_valid = 1; cmd_addr = 32'h0000_0600; cmd_wdata = 32'h7777_8888; cmd_write = 1;
        tick;
        cmd_valid = 0;
        req_ready = 1;
        tick;
        req_ready = 0;
        tick;
        #2 reset = 0;
        #1 checkResetState("async reset mid-WAIT");
        @(posedge clock);
        #1 reset = 1;
        resp_valid = 1; resp_data = 32'h9999_AAAA;
        tick;
        resp_valid = 0;
        check("post-reset resp spurious", spurious_count, 1);
        for (int i = 0; i < 8; i++) begin
            tick;
            if (rsp_valid !== 0 || cmd_ready !== 1) begin
                check("post-reset rsp_valid", rsp_valid, 0);
                check("post-reset cmd_ready", cmd_ready, 1);
            end
        end
        check("post-reset rsp_data", rsp_data, 0);
        check("post-reset req_valid", req_valid, 0);
        runVec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end
endmodule
